// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected output serializer.
// Holds the buffer occupancy enum and the beats-per-vector helper.
package fc_pkg;

    typedef enum logic [1:0] {
        eEMPTY = 2'd0,
        eONE   = 2'd1,
        eTWO   = 2'd2
    } occ_e;

    function automatic int ceil_div(input int h, input int l);
        return (h + l - 1) / l;
    endfunction

endpackage

// File: rtl/up_counter_enabled.sv
// Wrapping up-counter: counts 0..INPUT_MAX, advancing only when enabled.
// Ports: clk_i, reset_i (sync, active-high), enable_i, count_o.
module up_counter_enabled #(
    parameter int INPUT_MAX = 1,
    parameter int WIDTH     = (INPUT_MAX < 1) ? 1 : $clog2(INPUT_MAX + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(INPUT_MAX);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (enable_i) begin
            count_o <= (count_o == MAXV) ? '0 : count_o + 1'b1;
        end
    end

endmodule

// File: rtl/fc_output_serializer.sv
// Two-slot vector buffer that emits each LAYER_HEIGHT-word vector as
// ceil(LAYER_HEIGHT/LANES) beats of LANES words into a downstream FIFO.
// Ports: clk_i, reset_i (sync, active-high); upstream valid_i/ready_o/
// data_i; downstream wen_o/full_i/data_o/lane_valid_o/last_o.
// Macro FC_OUTPUT_SERIALIZER_RELU_EN: zero negative valid words on data_o.
module fc_output_serializer
    import fc_pkg::*;
#(
    parameter int LAYER_HEIGHT = 5,
    parameter int WORD_SIZE    = 16,
    parameter int LANES        = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    output logic                                   wen_o,
    input  logic                                   full_i,
    output logic [LANES-1:0][WORD_SIZE-1:0]        data_o,
    output logic [LANES-1:0]                       lane_valid_o,
    output logic                                   last_o
);

    localparam int BEATS = ceil_div(LAYER_HEIGHT, LANES);
    localparam int CW    = (BEATS < 2) ? 1 : $clog2(BEATS);
    localparam logic [CW-1:0] LASTB = CW'(BEATS - 1);

    typedef logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] vec_t;

    occ_e          occ_q, occ_d;
    logic          hd_q;
    vec_t          slot_q [2];
    vec_t          head;
    logic [CW-1:0] beat;
    logic          accept, pop, final_beat, wr_idx;

    logic [LANES-1:0][WORD_SIZE-1:0] beat_w [BEATS];
    logic [LANES-1:0]                beat_m [BEATS];

    assign ready_o    = (occ_q != eTWO);
    assign accept     = valid_i && ready_o;
    assign wen_o      = (occ_q != eEMPTY) && !full_i;
    assign final_beat = (beat == LASTB);
    assign pop        = wen_o && final_beat;
    assign last_o     = (occ_q != eEMPTY) && final_beat;

    // The tail is the free slot: the head itself when empty,
    // otherwise the other slot (even when the head is popping).
    assign wr_idx = (occ_q == eEMPTY) ? hd_q : ~hd_q;
    assign head   = slot_q[hd_q];

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, pop})
            2'b10:   occ_d = (occ_q == eEMPTY) ? eONE : eTWO;
            2'b01:   occ_d = (occ_q == eTWO) ? eONE : eEMPTY;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            occ_q <= eEMPTY;
            hd_q  <= 1'b0;
        end else begin
            occ_q <= occ_d;
            if (pop) hd_q <= ~hd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) slot_q[wr_idx] <= data_i;
    end

    up_counter_enabled #(
        .INPUT_MAX(BEATS - 1),
        .WIDTH    (CW)
    ) u_beat_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enable_i(wen_o),
        .count_o (beat)
    );

    // Static beat/lane -> element map; lanes past the vector end are zero.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            localparam int E = b * LANES + l;
            if (E < LAYER_HEIGHT) begin : g_used
                assign beat_w[b][l] = head[E];
                assign beat_m[b][l] = 1'b1;
            end else begin : g_pad
                assign beat_w[b][l] = '0;
                assign beat_m[b][l] = 1'b0;
            end
        end
    end

    function automatic logic [WORD_SIZE-1:0] act(
        input logic [WORD_SIZE-1:0] w
    );
`ifdef FC_OUTPUT_SERIALIZER_RELU_EN
        return w[WORD_SIZE-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    always_comb begin
        data_o       = '0;
        lane_valid_o = '0;
        if (occ_q != eEMPTY) begin
            lane_valid_o = beat_m[beat];
            for (int l = 0; l < LANES; l++) begin
                data_o[l] = act(beat_w[beat][l]);
            end
        end
    end

endmodule
